// File: rtl/tns_dec_rr_sched.sv
// Round-robin scheduler that shares one registered 18-bit TNS decoder among
// N_REQ requesters. Results come back in grant order through an output FIFO.
// Grants are credit-limited so the FIFO can never overflow.

`ifndef TNS_W00
`define BLEN06 17
`define TNS_W00 17'd1
`define TNS_W01 17'd2
`define TNS_W02 17'd4
`define TNS_W03 17'd7
`define TNS_W04 17'd13
`define TNS_W05 17'd24
`define TNS_W06 17'd44
`define TNS_W07 17'd81
`define TNS_W08 17'd149
`define TNS_W09 17'd274
`define TNS_W10 17'd504
`define TNS_W11 17'd927
`define TNS_W12 17'd1705
`define TNS_W13 17'd3136
`define TNS_W14 17'd5768
`define TNS_W15 17'd10609
`define TNS_W16 17'd19513
`define TNS_W17 17'd35890
`endif

// 18-bit TNS decoder: weighted bit sum, one registered cycle of latency.
module tns_dec18 (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [17:0]        code,
  output logic [`BLEN06-1:0] value
);
  localparam logic [`BLEN06-1:0] W [18] = '{
    `TNS_W00, `TNS_W01, `TNS_W02, `TNS_W03, `TNS_W04, `TNS_W05,
    `TNS_W06, `TNS_W07, `TNS_W08, `TNS_W09, `TNS_W10, `TNS_W11,
    `TNS_W12, `TNS_W13, `TNS_W14, `TNS_W15, `TNS_W16, `TNS_W17};

  logic [`BLEN06-1:0] sum;

  // Sum the weights of all set bits; illegal codewords decode as-is.
  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < 18; k++)
      if (code[k]) sum = sum + W[k];
  end

  // Register the decoded value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value <= '0;
    else        value <= sum;
  end
endmodule

module tns_dec_rr_sched #(
  parameter int N_REQ     = 4,
  parameter int IDW       = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [18*N_REQ-1:0]   req_code,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [`BLEN06-1:0]    rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);
  localparam int unsigned AW = $clog2(OUT_DEPTH);
  localparam logic [AW+1:0] DEPTH_OCC = (AW+2)'(OUT_DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(OUT_DEPTH);

  logic [IDW-1:0]           ptr, win, ptr_nxt, idx;
  logic                     found, grant_ok, accept, push, pop;
  logic [AW+1:0]            occ;

  logic                     s0_valid, s1_valid;
  logic [17:0]              s0_code;
  logic [IDW-1:0]           s0_id, s1_id;
  logic [`BLEN06-1:0]       dec_value;

  logic [IDW+`BLEN06-1:0]   mem [OUT_DEPTH];
  logic [AW-1:0]            wptr, rptr;
  logic [AW:0]              fifo_cnt;
  logic [IDW+`BLEN06-1:0]   head;

  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign push      = s1_valid;
  assign head      = mem[rptr];
  assign rsp_data  = rsp_valid ? head[`BLEN06-1:0] : '0;
  assign rsp_id    = rsp_valid ? head[IDW+`BLEN06-1:`BLEN06] : '0;
  assign busy      = s0_valid | s1_valid | rsp_valid;
  assign occ       = (AW+2)'(fifo_cnt) + (AW+2)'(s0_valid) + (AW+2)'(s1_valid);

  // Pick the first valid requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = IDW'((32'(ptr) + i) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Credit check and one-hot grant; a pop this cycle frees one slot when full.
  // The rst_n term keeps req_ready low while reset is asserted.
  always_comb begin
    grant_ok  = rst_n && found && ((occ < DEPTH_OCC) || ((occ == DEPTH_OCC) && pop));
    req_ready = '0;
    if (grant_ok) req_ready[win] = 1'b1;
    accept    = grant_ok;
    ptr_nxt   = (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
  end

  // RR pointer and the two pipeline stages around the decoder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      s0_valid <= 1'b0;
      s0_code  <= '0;
      s0_id    <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
    end else begin
      if (accept) ptr <= ptr_nxt;
      s0_valid <= accept;
      if (accept) begin
        s0_code <= req_code[18*win +: 18];
        s0_id   <= win;
      end
      s1_valid <= s0_valid;
      s1_id    <= s0_id;
    end
  end

  tns_dec18 u_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .code  (s0_code),
    .value (dec_value)
  );

  // Output FIFO; simultaneous push and pop are legal at any fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
      for (int unsigned i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {s1_id, dec_value};
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_cnt == DEPTH_CNT)));
endmodule

// File: tb/tb_tns_dec_rr_sched.sv
// Scoreboard bench for tns_dec_rr_sched: a stimulus process predicts grants
// and queues expected responses; a monitor pops and compares on each output.
module tb_tns_dec_rr_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [71:0] req_code;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [16:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  tns_dec_rr_sched #(.N_REQ(4), .IDW(2), .OUT_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    int unsigned data;
    int unsigned acc;
  } ent_t;

  ent_t        sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;
  int unsigned mptr   = 0;
  int unsigned dut_hs = 0;
  logic        in_rst = 1'b1;

  // Tribonacci weights, hand-listed.
  int unsigned tw [18] = '{1, 2, 4, 7, 13, 24, 44, 81, 149, 274, 504, 927,
                           1705, 3136, 5768, 10609, 19513, 35890};

  function automatic int unsigned dec(input logic [17:0] c);
    int unsigned s = 0;
    for (int k = 0; k < 18; k++) if (c[k]) s += tw[k];
    return s;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus with grant prediction.
  task automatic step(input logic [3:0] v, input logic [71:0] codes, input logic rr);
    logic        pop, ok, found;
    int unsigned win, k;
    logic [3:0]  exp_rdy;
    @(negedge clk);
    req_valid = v;
    req_code  = codes;
    rsp_ready = rr;
    #1;
    pop   = (sb.size() > 0) && (sb[0].acc + 3 <= cyc) && rr;
    ok    = (sb.size() < 4) || ((sb.size() == 4) && pop);
    found = 1'b0;
    win   = 0;
    for (int i = 0; i < 4; i++) begin
      k = (mptr + i) % 4;
      if (!found && v[k]) begin
        found = 1'b1;
        win   = k;
      end
    end
    exp_rdy = '0;
    if (found && ok) exp_rdy[win] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (|(req_valid & req_ready)) dut_hs++;
    if (exp_rdy != 0) begin
      sb.push_back('{win, dec(codes[18*win +: 18]), cyc});
      mptr = (win + 1) % 4;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, '0, 1'b1);
  endtask

  // Monitor: predicts rsp_valid/busy and compares popped responses.
  always @(negedge clk) begin
    ent_t e;
    #2;
    if (!in_rst) begin
      chk("rsp_valid", rsp_valid, (sb.size() > 0 && sb[0].acc + 3 <= cyc) ? 1 : 0);
      chk("busy", busy, (sb.size() > 0 && sb[0].acc < cyc) ? 1 : 0);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL rsp_unexpected: got id %0d data %0d expected no response", rsp_id, rsp_data);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_data", rsp_data, e.data);
        end
      end
    end
  end

  initial begin
    logic [71:0] codes;
    int unsigned hs0;

    // Reset state, with requests pending to confirm req_ready is held low.
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_code  = '0;
    rsp_ready = 1'b0;
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    req_valid = 4'h0;
    @(negedge clk);
    rst_n  = 1'b1;
    in_rst = 1'b0;

    // 1: single zero codeword from requester 0.
    step(4'b0001, '0, 1'b1);
    idle(4);

    // 2: all requesters valid, sink always ready.
    codes = {18'h2A5A5, 18'h00F0F, 18'h3FFFF, 18'h12345};
    for (int i = 0; i < 12; i++) begin
      step(4'b1111, codes, 1'b1);
      codes = {codes[70:0], codes[71] ^ codes[5]};
    end
    idle(4);

    // 3: sink stalled; credit caps accepted words at four.
    codes = {18'h00007, 18'h00030, 18'h01C00, 18'h30000};
    hs0 = dut_hs;
    for (int i = 0; i < 8; i++) step(4'b1111, codes, 1'b0);
    chk("credit_fill", dut_hs - hs0, 4);
    for (int i = 0; i < 8; i++) step(4'b1111, codes, 1'b1);
    idle(5);

    // 4: single-bit codewords on requester 2.
    for (int b = 0; b < 18; b++) begin
      codes = '0;
      codes[36 + b] = 1'b1;
      step(4'b0100, codes, 1'b1);
    end
    idle(4);

    // 5: pointer wrap: ptr to 1, then only req 3, then req 0 and 3.
    step(4'b0001, {18'h0, 18'h0, 18'h0, 18'h00011}, 1'b1);
    step(4'b1000, {18'h20001, 18'h0, 18'h0, 18'h0}, 1'b1);
    step(4'b1001, {18'h10002, 18'h0, 18'h0, 18'h00100}, 1'b1);
    step(4'b1000, {18'h10002, 18'h0, 18'h0, 18'h0}, 1'b1);
    idle(5);

    // 6: reset with two words in the pipeline and two in the FIFO.
    codes = {18'h00003, 18'h00005, 18'h00009, 18'h00011};
    for (int i = 0; i < 4; i++) step(4'b1111, codes, 1'b0);
    @(negedge clk);
    in_rst = 1'b1;
    rst_n  = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    chk("mid_rst_rsp_id", rsp_id, 0);
    chk("mid_rst_busy", busy, 0);
    sb.delete();
    mptr = 0;
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n  = 1'b1;
    in_rst = 1'b0;
    idle(6);
    step(4'b0010, {18'h0, 18'h0, 18'h00040, 18'h0}, 1'b1);
    idle(5);

    chk("drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
